// File: rtl/max_exp_group_ctrl.sv
// ============================================================================
// Module   : max_exp_group_ctrl
// Brief    : Folds four-exponent beats into a per-group unsigned maximum and
//            holds the shared exponent on a valid/ready output port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module max_exp_group_ctrl #(
    parameter int DATA_WIDTH = 6,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_exp [3:0],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_max_exp,
    output logic [LEN_WIDTH-1:0]  out_beats
);

    localparam logic [LEN_WIDTH-1:0] c_one = LEN_WIDTH'(1);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    state_t                r_state;
    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic [LEN_WIDTH-1:0]  r_len_q;
    logic [DATA_WIDTH-1:0] r_max_q;

    logic [DATA_WIDTH-1:0] w_max_hi;
    logic [DATA_WIDTH-1:0] w_max_lo;
    logic [DATA_WIDTH-1:0] w_beat_max;
    logic                  w_accept;
    logic                  w_first;
    logic [LEN_WIDTH-1:0]  w_cfg_eff;
    logic [LEN_WIDTH-1:0]  w_eff_len;
    logic [LEN_WIDTH-1:0]  w_cnt_next;
    logic                  w_last;

    // Two-level pairwise reduction of the beat's four exponents.
    assign w_max_hi   = (in_exp[3] > in_exp[2]) ? in_exp[3] : in_exp[2];
    assign w_max_lo   = (in_exp[1] > in_exp[0]) ? in_exp[1] : in_exp[0];
    assign w_beat_max = (w_max_hi > w_max_lo) ? w_max_hi : w_max_lo;

    assign in_ready   = (r_state == ACCUM);
    assign w_accept   = in_valid && in_ready;
    assign w_first    = (r_beat_cnt == '0);
    assign w_cfg_eff  = (cfg_len == '0) ? c_one : cfg_len;
    // The first beat closes against the length it is sampling right now.
    assign w_eff_len  = w_first ? w_cfg_eff : r_len_q;
    assign w_cnt_next = r_beat_cnt + c_one;
    assign w_last     = (w_cnt_next == w_eff_len);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ACCUM;
            r_beat_cnt <= '0;
            r_len_q    <= c_one;
            r_max_q    <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (w_first) begin
                            r_len_q <= w_cfg_eff;
                            r_max_q <= w_beat_max;
                        end else if (w_beat_max > r_max_q) begin
                            r_max_q <= w_beat_max;
                        end
                        if (w_last) begin
                            r_state    <= OUT;
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= w_cnt_next;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_state <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign out_valid   = (r_state == OUT);
    assign out_max_exp = r_max_q;
    assign out_beats   = r_len_q;

endmodule

`default_nettype wire

// File: tb/tb_max_exp_group_ctrl.sv
// ============================================================================
// Module   : tb_max_exp_group_ctrl
// Brief    : Scoreboard bench for max_exp_group_ctrl with directed and random groups.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_max_exp_group_ctrl;

    localparam int DW = 6;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_exp [3:0];
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_max_exp;
    logic [LW-1:0] out_beats;

    max_exp_group_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_len    (cfg_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_max_exp(out_max_exp),
        .out_beats  (out_beats)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] mx;
        logic [LW-1:0] beats;
    } exp_t;

    exp_t          sb [$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            rdy_mode = 1;     // 0 random, 1 always ready, 2 stalled
    bit            mon_en = 1'b0;
    logic [DW-1:0] g_exp [16][4];

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // out_ready changes just after the rising edge so negedge samplers see it settled.
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: pops the expected result on each handshake; also checks holding.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("in_ready_vs_out_valid", int'(in_ready), int'(!out_valid));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    chk("out_max_exp", int'(out_max_exp), int'(sb[0].mx));
                    chk("out_beats", int'(out_beats), int'(sb[0].beats));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic scramble();
        for (int k = 0; k < 4; k++) in_exp[k] = DW'($urandom);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_beat(input logic [DW-1:0] e0, e1, e2, e3, input bit last, input exp_t e);
        int n = 0;
        in_valid  = 1'b1;
        in_exp[0] = e0;
        in_exp[1] = e1;
        in_exp[2] = e2;
        in_exp[3] = e3;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", int'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        if (last) sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        if (last) chk("latency_out_valid", int'(out_valid), 1);
    endtask

    // Reference: the group result is the largest of every exponent sent.
    task automatic run_group(input logic [LW-1:0] cfg, input bit gaps, input bit chg_cfg);
        int   eff;
        int   mx;
        exp_t e;
        eff = (cfg == 0) ? 1 : int'(cfg);
        mx  = 0;
        for (int b = 0; b < eff; b++)
            for (int k = 0; k < 4; k++)
                if (int'(g_exp[b][k]) > mx) mx = int'(g_exp[b][k]);
        e.mx    = DW'(mx);
        e.beats = LW'(eff);
        cfg_len = cfg;
        for (int b = 0; b < eff; b++) begin
            if (gaps) begin
                int g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++) begin
                    scramble();
                    @(negedge clk);
                end
            end
            send_beat(g_exp[b][0], g_exp[b][1], g_exp[b][2], g_exp[b][3], b == eff - 1, e);
            if (b == 0 && chg_cfg) cfg_len = LW'($urandom);
        end
    endtask

    task automatic fill_random();
        for (int b = 0; b < 16; b++)
            for (int k = 0; k < 4; k++)
                g_exp[b][k] = ($urandom_range(0, 15) == 0) ? DW'(63) : DW'($urandom_range(0, 62));
    endtask

    task automatic set_beat(input int b, input int a0, a1, a2, a3);
        g_exp[b][0] = DW'(a0);
        g_exp[b][1] = DW'(a1);
        g_exp[b][2] = DW'(a2);
        g_exp[b][3] = DW'(a3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        scramble();
        repeat (3) @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_max_exp", int'(out_max_exp), 0);
        chk("reset_out_beats", int'(out_beats), 1);
        chk("reset_in_ready", int'(in_ready), 1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Two-beat group, then in_ready low for exactly one cycle.
        set_beat(0, 3, 9, 1, 4);
        set_beat(1, 7, 2, 8, 5);
        run_group(2, 1'b0, 1'b0);
        chk("busy_cycle_in_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("after_handshake_in_ready", int'(in_ready), 1);

        // Length 0 behaves as 1, all-ones exponent is the largest.
        set_beat(0, 0, 0, 63, 1);
        run_group(0, 1'b0, 1'b0);

        // First beat loads rather than comparing against a stale 40.
        set_beat(0, 40, 1, 2, 3);
        run_group(1, 1'b0, 1'b0);
        set_beat(0, 5, 5, 5, 5);
        set_beat(1, 0, 1, 2, 3);
        set_beat(2, 4, 4, 1, 0);
        run_group(3, 1'b1, 1'b0);

        // Backpressure: result 12 held while a new beat waits.
        while (sb.size() != 0) @(negedge clk);
        rdy_mode = 2;
        @(negedge clk);
        set_beat(0, 12, 3, 7, 11);
        run_group(1, 1'b0, 1'b0);
        set_beat(0, 60, 1, 2, 3);
        fork
            run_group(1, 1'b0, 1'b0);
            begin
                for (int c = 0; c < 5; c++) begin
                    chk("stall_in_ready", int'(in_ready), 0);
                    chk("stall_out_max_exp", int'(out_max_exp), 12);
                    @(negedge clk);
                end
                rdy_mode = 1;
            end
        join

        // Mid-group length change is ignored; idle gaps allowed.
        set_beat(0, 1, 2, 3, 4);
        set_beat(1, 9, 8, 7, 6);
        set_beat(2, 0, 0, 0, 33);
        set_beat(3, 2, 2, 2, 2);
        cfg_len = 4;
        run_group(4, 1'b1, 1'b0);
        // Same group shape but with cfg_len forced to 1 after the first beat.
        set_beat(0, 1, 1, 1, 1);
        set_beat(1, 2, 2, 2, 2);
        set_beat(2, 3, 3, 3, 3);
        set_beat(3, 44, 4, 4, 4);
        fork
            run_group(4, 1'b1, 1'b0);
            begin
                while (!(in_valid && in_ready)) @(negedge clk);
                @(negedge clk);
                cfg_len = 1;
            end
        join

        // Reset mid-group discards the partial result.
        while (sb.size() != 0) @(negedge clk);
        set_beat(0, 50, 0, 0, 0);
        set_beat(1, 51, 0, 0, 0);
        cfg_len = 4;
        send_beat(g_exp[0][0], g_exp[0][1], g_exp[0][2], g_exp[0][3], 1'b0, '0);
        send_beat(g_exp[1][0], g_exp[1][1], g_exp[1][2], g_exp[1][3], 1'b0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_beats", int'(out_beats), 1);
        set_beat(0, 17, 3, 0, 2);
        run_group(1, 1'b0, 1'b0);

        // Random groups with random gaps, backpressure and cfg churn.
        rdy_mode = 0;
        for (int g = 0; g < 60; g++) begin
            fill_random();
            run_group(LW'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        rdy_mode = 1;
        begin
            int n = 0;
            while (sb.size() != 0 && n < 500) begin
                @(negedge clk);
                n++;
            end
        end
        chk("drain_queue_empty", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
